// File: rtl/tlb_op_ctrl.sv
// Sequences TLB maintenance ops from EX into the TLB: one-hot command pulse, CSR settle
// window, optional refetch flush at PC+4, then a retire pulse (or ine for illegal encodings).
module tlb_op_ctrl #(
    parameter int unsigned CSR_SETTLE = 1,
    parameter bit          REFETCH_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [4:0]  req_invtlb_op,
    input  logic [9:0]  req_invtlb_asid,
    input  logic [18:0] req_invtlb_vppn,
    input  logic [31:0] req_pc,
    input  logic        kill,
    output logic        tlbsrch,
    output logic        tlbrd,
    output logic        tlbwr,
    output logic        tlbfill,
    output logic        invtlb,
    output logic [4:0]  invtlb_op,
    output logic [9:0]  invtlb_asid,
    output logic [18:0] invtlb_vppn,
    output logic        busy,
    output logic        flush_valid,
    output logic [31:0] flush_pc,
    input  logic        flush_ready,
    output logic        done,
    output logic        ine
);

    localparam logic [2:0] OpSrch = 3'd0;
    localparam logic [2:0] OpRd   = 3'd1;
    localparam logic [2:0] OpWr   = 3'd2;
    localparam logic [2:0] OpFill = 3'd3;
    localparam logic [2:0] OpInv  = 3'd4;

    localparam logic [2:0] SettleInit = 3'(CSR_SETTLE - 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StSettle,
        StFlush,
        StDone,
        StExcp
    } state_e;

    state_e      state_q;
    logic [2:0]  op_q;
    logic [2:0]  cnt_q;
    logic [4:0]  inv_op_q;
    logic [9:0]  inv_asid_q;
    logic [18:0] inv_vppn_q;
    logic [31:0] flush_pc_q;

    logic accept;
    logic op_legal;
    logic issue_fire;

    assign req_ready = (state_q == StIdle) && !kill;
    assign accept    = req_valid && req_ready;
    assign op_legal  = (req_op <= OpFill) || ((req_op == OpInv) && (req_invtlb_op <= 5'd6));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            op_q       <= 3'd0;
            cnt_q      <= 3'd0;
            inv_op_q   <= 5'd0;
            inv_asid_q <= 10'd0;
            inv_vppn_q <= 19'd0;
            flush_pc_q <= 32'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        op_q       <= req_op;
                        inv_op_q   <= req_invtlb_op;
                        inv_asid_q <= req_invtlb_asid;
                        inv_vppn_q <= req_invtlb_vppn;
                        flush_pc_q <= req_pc + 32'd4;
                        state_q    <= op_legal ? StIssue : StExcp;
                    end
                end
                StIssue: begin
                    // A kill here squashes the op before the TLB sees it.
                    if (kill) begin
                        state_q <= StIdle;
                    end else begin
                        state_q <= StSettle;
                        cnt_q   <= SettleInit;
                    end
                end
                StSettle: begin
                    if (cnt_q == 3'd0) begin
                        state_q <= (REFETCH_EN && (op_q != OpSrch)) ? StFlush : StDone;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                StFlush: begin
                    if (flush_ready) begin
                        state_q <= StDone;
                    end
                end
                StDone:  state_q <= StIdle;
                StExcp:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign issue_fire = (state_q == StIssue) && !kill;

    assign tlbsrch = issue_fire && (op_q == OpSrch);
    assign tlbrd   = issue_fire && (op_q == OpRd);
    assign tlbwr   = issue_fire && (op_q == OpWr);
    assign tlbfill = issue_fire && (op_q == OpFill);
    assign invtlb  = issue_fire && (op_q == OpInv);

    assign invtlb_op   = inv_op_q;
    assign invtlb_asid = inv_asid_q;
    assign invtlb_vppn = inv_vppn_q;

    assign busy        = (state_q != StIdle);
    assign flush_valid = (state_q == StFlush);
    assign flush_pc    = flush_pc_q;
    assign done        = (state_q == StDone);
    assign ine         = (state_q == StExcp);

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl: default build plus a CSR_SETTLE=3 instance for settle latency.
module tb_tlb_op_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [4:0]  req_invtlb_op;
    logic [9:0]  req_invtlb_asid;
    logic [18:0] req_invtlb_vppn;
    logic [31:0] req_pc;
    logic        kill;
    logic        tlbsrch, tlbrd, tlbwr, tlbfill, invtlb;
    logic [4:0]  invtlb_op;
    logic [9:0]  invtlb_asid;
    logic [18:0] invtlb_vppn;
    logic        busy, flush_valid, done, ine;
    logic [31:0] flush_pc;
    logic        flush_ready;

    logic        d3_req_ready;
    logic        d3_tlbsrch, d3_tlbrd, d3_tlbwr, d3_tlbfill, d3_invtlb;
    logic [4:0]  d3_invtlb_op;
    logic [9:0]  d3_invtlb_asid;
    logic [18:0] d3_invtlb_vppn;
    logic        d3_busy, d3_flush_valid, d3_done, d3_ine;
    logic [31:0] d3_flush_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tlb_op_ctrl u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_invtlb_op   (req_invtlb_op),
        .req_invtlb_asid (req_invtlb_asid),
        .req_invtlb_vppn (req_invtlb_vppn),
        .req_pc          (req_pc),
        .kill            (kill),
        .tlbsrch         (tlbsrch),
        .tlbrd           (tlbrd),
        .tlbwr           (tlbwr),
        .tlbfill         (tlbfill),
        .invtlb          (invtlb),
        .invtlb_op       (invtlb_op),
        .invtlb_asid     (invtlb_asid),
        .invtlb_vppn     (invtlb_vppn),
        .busy            (busy),
        .flush_valid     (flush_valid),
        .flush_pc        (flush_pc),
        .flush_ready     (flush_ready),
        .done            (done),
        .ine             (ine)
    );

    tlb_op_ctrl #(
        .CSR_SETTLE (3)
    ) u_dut3 (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (d3_req_ready),
        .req_op          (req_op),
        .req_invtlb_op   (req_invtlb_op),
        .req_invtlb_asid (req_invtlb_asid),
        .req_invtlb_vppn (req_invtlb_vppn),
        .req_pc          (req_pc),
        .kill            (kill),
        .tlbsrch         (d3_tlbsrch),
        .tlbrd           (d3_tlbrd),
        .tlbwr           (d3_tlbwr),
        .tlbfill         (d3_tlbfill),
        .invtlb          (d3_invtlb),
        .invtlb_op       (d3_invtlb_op),
        .invtlb_asid     (d3_invtlb_asid),
        .invtlb_vppn     (d3_invtlb_vppn),
        .busy            (d3_busy),
        .flush_valid     (d3_flush_valid),
        .flush_pc        (d3_flush_pc),
        .flush_ready     (flush_ready),
        .done            (d3_done),
        .ine             (d3_ine)
    );

    // {srch, rd, wr, fill, inv, flush_valid, done, busy, ine, req_ready}
    function automatic logic [9:0] obs_vec();
        return {tlbsrch, tlbrd, tlbwr, tlbfill, invtlb, flush_valid, done, busy, ine, req_ready};
    endfunction

    // Pulses must be one-hot-or-zero and only while the controller is busy.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if (($countones({tlbsrch, tlbrd, tlbwr, tlbfill, invtlb}) > 1) ||
                (({tlbsrch, tlbrd, tlbwr, tlbfill, invtlb} != 5'd0) && !busy)) begin
                errors++;
                $display("FAIL pulse_invariant at %0t: pulses=%b busy=%b required one-hot0 and busy",
                         $time, {tlbsrch, tlbrd, tlbwr, tlbfill, invtlb}, busy);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_op(input logic [2:0] op, input logic [4:0] iop, input logic [9:0] asid,
                            input logic [18:0] vppn, input logic [31:0] pc);
        req_valid       = 1'b1;
        req_op          = op;
        req_invtlb_op   = iop;
        req_invtlb_asid = asid;
        req_invtlb_vppn = vppn;
        req_pc          = pc;
        tick();
        req_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (obs_vec() !== 10'b0000000001) begin
            errors++;
            $display("FAIL reset_outputs: got %b required %b", obs_vec(), 10'b0000000001);
        end
        checks++;
        if ({flush_pc, invtlb_op, invtlb_asid, invtlb_vppn} !== 66'd0) begin
            errors++;
            $display("FAIL reset_latched: got pc=%h op=%h asid=%h vppn=%h required all 0",
                     flush_pc, invtlb_op, invtlb_asid, invtlb_vppn);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs_vec() !== 10'b0000000001) begin
            errors++;
            $display("FAIL reset_release_idle: got %b required %b", obs_vec(), 10'b0000000001);
        end
    endtask

    task automatic test_tlbwr();
        logic [9:0] exp_v [0:4];
        exp_v = '{10'b0010000100, 10'b0000000100, 10'b0000010100, 10'b0000001100,
                  10'b0000000001};
        flush_ready = 1'b1;
        start_op(3'd2, 5'd0, 10'd0, 19'd0, 32'h1c000100);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs_vec() !== exp_v[i]) begin
                errors++;
                $display("FAIL tlbwr_T+%0d: got %b required %b", i + 1, obs_vec(), exp_v[i]);
            end
            if (i == 2) begin
                checks++;
                if (flush_pc !== 32'h1c000104) begin
                    errors++;
                    $display("FAIL tlbwr_flush_pc: got %h required 1c000104", flush_pc);
                end
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_tlbsrch();
        logic [9:0] exp_v [0:3];
        exp_v = '{10'b1000000100, 10'b0000000100, 10'b0000001100, 10'b0000000001};
        flush_ready = 1'b0;
        start_op(3'd0, 5'd0, 10'd0, 19'd0, 32'h1c000200);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_vec() !== exp_v[i]) begin
                errors++;
                $display("FAIL tlbsrch_T+%0d: got %b required %b", i + 1, obs_vec(), exp_v[i]);
            end
            if (i < 3) tick();
        end
    endtask

    task automatic test_invtlb();
        flush_ready = 1'b0;
        // PC at the top of the address space: PC+4 wraps to 0.
        start_op(3'd4, 5'd5, 10'h2a, 19'h12345, 32'hfffffffc);
        checks++;
        if (obs_vec() !== 10'b0000100100 || invtlb_op !== 5'd5 || invtlb_asid !== 10'h2a ||
            invtlb_vppn !== 19'h12345) begin
            errors++;
            $display("FAIL invtlb_issue: got %b op=%h asid=%h vppn=%h required %b op=5 asid=2a vppn=12345",
                     obs_vec(), invtlb_op, invtlb_asid, invtlb_vppn, 10'b0000100100);
        end
        tick();
        checks++;
        if (obs_vec() !== 10'b0000000100) begin
            errors++;
            $display("FAIL invtlb_settle: got %b required %b", obs_vec(), 10'b0000000100);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (obs_vec() !== 10'b0000010100 || flush_pc !== 32'h0) begin
                errors++;
                $display("FAIL invtlb_flush_hold_%0d: got %b pc=%h required %b pc=00000000",
                         k, obs_vec(), flush_pc, 10'b0000010100);
            end
        end
        flush_ready = 1'b1;
        #1;
        tick();
        checks++;
        if (obs_vec() !== 10'b0000001100) begin
            errors++;
            $display("FAIL invtlb_done: got %b required %b", obs_vec(), 10'b0000001100);
        end
        flush_ready = 1'b0;
        tick();
        checks++;
        if (obs_vec() !== 10'b0000000001) begin
            errors++;
            $display("FAIL invtlb_idle: got %b required %b", obs_vec(), 10'b0000000001);
        end
    endtask

    task automatic test_invalid();
        logic [2:0] ops  [0:2];
        logic [4:0] iops [0:2];
        ops  = '{3'd4, 3'd6, 3'd5};
        iops = '{5'd7, 5'd0, 5'd31};
        flush_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            start_op(ops[c], iops[c], 10'h1, 19'h1, 32'h1c000300);
            checks++;
            if (obs_vec() !== 10'b0000000110) begin
                errors++;
                $display("FAIL invalid_%0d_ine: got %b required %b", c, obs_vec(), 10'b0000000110);
            end
            tick();
            checks++;
            if (obs_vec() !== 10'b0000000001) begin
                errors++;
                $display("FAIL invalid_%0d_idle: got %b required %b", c, obs_vec(),
                         10'b0000000001);
            end
        end
        flush_ready = 1'b0;
    endtask

    task automatic test_kill();
        logic [9:0] exp_v [0:3];
        // Kill in the ISSUE cycle squashes the pulse.
        start_op(3'd1, 5'd0, 10'd0, 19'd0, 32'h1c000400);
        kill = 1'b1;
        #1;
        checks++;
        if (obs_vec() !== 10'b0000000100) begin
            errors++;
            $display("FAIL kill_issue: got %b required %b", obs_vec(), 10'b0000000100);
        end
        tick();
        kill = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== 10'b0000000001) begin
            errors++;
            $display("FAIL kill_issue_idle: got %b required %b", obs_vec(), 10'b0000000001);
        end
        tick();
        checks++;
        if (obs_vec() !== 10'b0000000001) begin
            errors++;
            $display("FAIL kill_issue_quiet: got %b required %b", obs_vec(), 10'b0000000001);
        end

        // Kill after ISSUE is ignored: the op still flushes and retires.
        flush_ready = 1'b1;
        start_op(3'd3, 5'd0, 10'd0, 19'd0, 32'h1c000500);
        checks++;
        if (obs_vec() !== 10'b0001000100) begin
            errors++;
            $display("FAIL kill_late_issue: got %b required %b", obs_vec(), 10'b0001000100);
        end
        tick();
        kill = 1'b1;
        #1;
        exp_v = '{10'b0000000100, 10'b0000010100, 10'b0000001100, 10'b0000000000};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_vec() !== exp_v[i]) begin
                errors++;
                $display("FAIL kill_late_T+%0d: got %b required %b", i + 2, obs_vec(), exp_v[i]);
            end
            if (i < 3) tick();
        end

        // Kill in IDLE blocks acceptance.
        req_valid = 1'b1;
        req_op    = 3'd2;
        #1;
        checks++;
        if (obs_vec() !== 10'b0000000000) begin
            errors++;
            $display("FAIL kill_idle_ready: got %b required %b", obs_vec(), 10'b0000000000);
        end
        tick();
        checks++;
        if (obs_vec() !== 10'b0000000000) begin
            errors++;
            $display("FAIL kill_idle_no_accept: got %b required %b", obs_vec(), 10'b0000000000);
        end
        req_valid   = 1'b0;
        kill        = 1'b0;
        flush_ready = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== 10'b0000000001) begin
            errors++;
            $display("FAIL kill_idle_release: got %b required %b", obs_vec(), 10'b0000000001);
        end
    endtask

    task automatic test_reset_in_flush();
        flush_ready = 1'b0;
        start_op(3'd2, 5'd3, 10'h3ff, 19'h7ffff, 32'h1c000600);
        tick();
        tick();
        checks++;
        if (obs_vec() !== 10'b0000010100 || flush_pc !== 32'h1c000604) begin
            errors++;
            $display("FAIL rstflush_pre: got %b pc=%h required %b pc=1c000604", obs_vec(),
                     flush_pc, 10'b0000010100);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (obs_vec() !== 10'b0000000001 || flush_pc !== 32'h0 || invtlb_asid !== 10'h0 ||
            invtlb_vppn !== 19'h0 || invtlb_op !== 5'h0) begin
            errors++;
            $display("FAIL rstflush_post: got %b pc=%h asid=%h vppn=%h op=%h required %b and zeros",
                     obs_vec(), flush_pc, invtlb_asid, invtlb_vppn, invtlb_op, 10'b0000000001);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_settle3();
        logic [3:0] exp_v [0:6];
        // {tlbfill, flush_valid, done, busy} of the CSR_SETTLE=3 instance
        exp_v = '{4'b1001, 4'b0001, 4'b0001, 4'b0001, 4'b0101, 4'b0011, 4'b0000};
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        flush_ready = 1'b1;
        start_op(3'd3, 5'd0, 10'd0, 19'd0, 32'h1c000700);
        for (int i = 0; i < 7; i++) begin
            checks++;
            if ({d3_tlbfill, d3_flush_valid, d3_done, d3_busy} !== exp_v[i]) begin
                errors++;
                $display("FAIL settle3_T+%0d: got %b required %b", i + 1,
                         {d3_tlbfill, d3_flush_valid, d3_done, d3_busy}, exp_v[i]);
            end
            if (i < 6) tick();
        end
        flush_ready = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        req_valid       = 1'b0;
        req_op          = 3'd0;
        req_invtlb_op   = 5'd0;
        req_invtlb_asid = 10'd0;
        req_invtlb_vppn = 19'd0;
        req_pc          = 32'd0;
        kill            = 1'b0;
        flush_ready     = 1'b0;
        test_reset();
        test_tlbwr();
        test_tlbsrch();
        test_invtlb();
        test_invalid();
        test_kill();
        test_reset_in_flush();
        test_settle3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlb_op_ctrl.md
Name: tlb_op_ctrl

Overview:
- Sequences the TLB maintenance instructions (tlbsrch, tlbrd, tlbwr, tlbfill, invtlb) from the execute stage into the TLB block.
- Accepts one op at a time over a valid/ready handshake and drives single-cycle one-hot command pulses with latched invtlb operands.
- Holds the pipeline through a CSR settle window, then requests a refetch flush at PC+4 before reporting completion.
- Sits between the EX/MEM stage, the TLB, and the pipeline flush logic.

Parameters:
- CSR_SETTLE, 1, cycles (1..7) waited after the command pulse so TLB-driven CSR writes are visible before completion.
- REFETCH_EN, 1, when 1, every op except tlbsrch requests a refetch flush; when 0, no flush is ever requested.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  TLB op pending from EX.
- req_ready  out  1  op accepted when req_valid & req_ready.
- req_op  in  3  0=srch, 1=rd, 2=wr, 3=fill, 4=inv; 5..7 reserved.
- req_invtlb_op  in  5  invtlb op field.
- req_invtlb_asid  in  10  invtlb asid operand.
- req_invtlb_vppn  in  19  invtlb vppn operand.
- req_pc  in  32  PC of the TLB instruction.
- kill  in  1  older-instruction flush.
- tlbsrch, tlbrd, tlbwr, tlbfill, invtlb  out  1 each  one-hot command pulses to the TLB.
- invtlb_op  out  5  latched operand.
- invtlb_asid  out  10  latched operand.
- invtlb_vppn  out  19  latched operand.
- busy  out  1  stall request to IF/ID/EX.
- flush_valid  out  1  refetch request.
- flush_pc  out  32  refetch target.
- flush_ready  in  1  flush accepted.
- done  out  1  retire pulse.
- ine  out  1  instruction-not-exist exception pulse.

Behaviour:
- **States:** IDLE, ISSUE, SETTLE, FLUSH, DONE, EXCP. Reset (rst_n=0 at a clk edge, any state) → IDLE.
- **Reset values:** every output 0 except req_ready=1. All latched operands, flush_pc and the settle counter cleared.
- **Handshake:**
  - req_ready = (state==IDLE) & ~kill.
  - On accept, latch op, invtlb operands and req_pc+4 (mod 2^32).
- **IDLE:**
  - On accept with req_op in 0..3, or req_op==4 with req_invtlb_op ≤ 6 → ISSUE.
  - On accept with req_op==4 and req_invtlb_op ≥ 7, or req_op ≥ 5 → EXCP.
- **ISSUE (1 cycle):**
  - If kill=0: assert exactly the one command pulse matching the op; invtlb_* stay stable while invtlb=1; → SETTLE; counter loaded with CSR_SETTLE-1.
  - If kill=1: no pulse; → IDLE.
- **SETTLE:** counter decrements each cycle. At 0: → FLUSH if REFETCH_EN & op≠srch, else → DONE.
- **FLUSH:**
  - flush_valid=1 and flush_pc held constant until flush_ready=1. On that cycle → DONE.
  - flush_ready while not in FLUSH is ignored.
- **DONE:** done=1 for 1 cycle → IDLE.
- **EXCP:** ine=1 for 1 cycle; no command pulse, no flush, no done → IDLE.
- **busy** = (state≠IDLE). It is 0 in IDLE even while req_valid=1.
- **kill after ISSUE** is ignored: the op has modified TLB/CSR state and must complete and flush.
- **Latency**, accept at cycle T, CSR_SETTLE=1:
  - pulse at T+1, SETTLE at T+2, flush_valid from T+3, done the cycle after the flush handshake. Best case done=T+4.
  - tlbsrch: done=T+3.
  - Invalid op: ine=T+1.
- **Back-to-back:** the next accept is earliest the cycle after done/ine (state back in IDLE).
- **Invariants:**
  - At most one of the five command pulses is high in any cycle.
  - No command pulse outside ISSUE.

Test Plan:
- Reset then tlbwr accepted at T, req_pc=0x1c000100, flush_ready tied 1 → tlbwr=1 only at T+1; flush_valid=1 at T+3 with flush_pc=0x1c000104; done=1 at T+4; busy=1 over T+1..T+4.
- tlbsrch accepted at T → tlbsrch pulse T+1; flush_valid never asserted; done at T+3; req_ready=1 again at T+4.
- invtlb op=5, asid=0x2a, vppn=0x12345 → at T+1 invtlb=1, invtlb_op=5, invtlb_asid=0x2a, invtlb_vppn=0x12345. flush_ready held 0 for 4 cycles → flush_valid and flush_pc stable throughout; done one cycle after flush_ready rises.
- invtlb op=7, and separately req_op=6 → ine=1 at T+1; no command pulse, no flush_valid, no done.
- kill=1 in the ISSUE cycle → no pulse, return to IDLE next cycle. kill=1 during SETTLE → flush and done still occur. kill=1 in IDLE with req_valid=1 → req_ready=0, no accept.
- rst_n=0 during FLUSH → next cycle flush_valid=0, busy=0, req_ready=1, all pulses 0. CSR_SETTLE=3 build: tlbfill done at T+6 with flush_ready=1.
